alarm_buzzer: RTL

//  Annunciator on the far side of the alarm controller's ringing interface: consumes alarm_ringing and drives the piezo.

---
 rtl/clock_pkg.sv | 39 +++
 rtl/alarm_buzzer_tone_gen.sv | 47 ++++
 rtl/alarm_buzzer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Constants shared by the alarm-clock blocks (alarm controller, LCD driver,
//   alarm_buzzer): the annunciator FSM state encoding, the second-counter
//   width and a helper that sizes millisecond counters from their longest
//   interval.
// -----------------------------------------------------------------------------
package clock_pkg;

    // Annunciator FSM encoding (3 bits).
    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_BEEP_ON_ENC  = 3'd1;
    localparam logic [2:0] ST_BEEP_OFF_ENC = 3'd2;
    localparam logic [2:0] ST_GAP_ENC      = 3'd3;
    localparam logic [2:0] ST_HOLD_ENC     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_BEEP_ON  = ST_BEEP_ON_ENC,
        ST_BEEP_OFF = ST_BEEP_OFF_ENC,
        ST_GAP      = ST_GAP_ENC,
        ST_HOLD     = ST_HOLD_ENC
    } buzz_state_t;

    // Second counter: 8 bits, saturating.
    localparam int               SEC_W   = 8;
    localparam logic [SEC_W-1:0] SEC_MAX = '1;

    // Width of a millisecond counter that must hold the longest of three
    // intervals.
    function automatic int ms_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/alarm_buzzer_tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
//   Square-wave divider for the piezo tone. While en is high the phase output
//   flips every TONE_HALF clk_1k cycles. clr synchronously returns the divider
//   and the phase to 0 and has priority over en, so the output is low whenever
//   the tone is not running.
// Ports
//   clk_1k  in   1 kHz system clock
//   rst_n   in   asynchronous active-low reset
//   en      in   advance the divider this cycle
//   clr     in   synchronous clear of divider and phase
//   tone    out  tone phase (registered)
// -----------------------------------------------------------------------------
module tone_gen
    import clock_pkg::*;
#(
    parameter int TONE_HALF = 1
) (
    input  logic clk_1k,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tone
);

    localparam int CW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (clr) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (en) begin
            if (div_cnt == CW'(TONE_HALF - 1)) begin
                div_cnt <= '0;
                tone    <= ~tone;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_buzzer.sv
// -----------------------------------------------------------------------------
// alarm_buzzer
//   Annunciator behind the alarm controller's ringing interface. Turns the
//   alarm_ringing level into a grouped beep pattern on the piezo, lights the
//   beep LED during each beep, and enforces a ring timeout counted in
//   tick_1hz pulses. On timeout it emits a one-cycle auto_stop pulse which
//   the top level ORs into the controller's btn_stop.
//   Optional build macro ALARM_BUZZER_ESCALATE_EN: the inter-group gap halves
//   every 10 ringing seconds (floored at BEEP_OFF_MS).
// Ports
//   clk_1k         in   1 kHz system clock
//   rst_n          in   asynchronous active-low reset
//   tick_1hz       in   one-cycle pulse per second
//   alarm_ringing  in   high while the alarm rings
//   btn_stop       in   one-cycle stop pulse
//   buzzer_out     out  piezo drive (registered)
//   beep_led       out  high while a beep is sounding (registered)
//   ring_active    out  high in any state except IDLE (registered)
//   auto_stop      out  one-cycle pulse when the ring timeout expires
// -----------------------------------------------------------------------------
module alarm_buzzer
    import clock_pkg::*;
#(
    parameter int TONE_HALF   = 1,
    parameter int BEEP_ON_MS  = 100,
    parameter int BEEP_OFF_MS = 100,
    parameter int GROUP_BEEPS = 4,
    parameter int GAP_MS      = 600,
    parameter int TIMEOUT_S   = 60
) (
    input  logic clk_1k,
    input  logic rst_n,
    input  logic tick_1hz,
    input  logic alarm_ringing,
    input  logic btn_stop,
    output logic buzzer_out,
    output logic beep_led,
    output logic ring_active,
    output logic auto_stop
);

    localparam int MS_W = ms_cnt_width(BEEP_ON_MS, BEEP_OFF_MS, GAP_MS);
    localparam int BC_W = (GROUP_BEEPS < 2) ? 1 : $clog2(GROUP_BEEPS);

    buzz_state_t      state;
    logic             ring_q;
    logic [MS_W-1:0]  ms_cnt;
    logic [BC_W-1:0]  beep_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic [SEC_W-1:0] sec_next;
    logic [MS_W-1:0]  gap_eff;
    logic             rise;
    logic             active;
    logic             timeout;
    logic             on_done;
    logic             off_done;
    logic             gap_done;
    logic             tone_en;
    logic             tone_clr;

    assign rise     = alarm_ringing & ~ring_q;
    assign active   = (state == ST_BEEP_ON) || (state == ST_BEEP_OFF) || (state == ST_GAP);
    assign sec_next = (sec_cnt == SEC_MAX) ? sec_cnt : sec_cnt + 1'b1;

    // Timeout fires on the tick that brings the count to TIMEOUT_S, so
    // auto_stop appears the cycle right after that tick.
    assign timeout  = active & alarm_ringing & tick_1hz & (sec_next == SEC_W'(TIMEOUT_S));

    assign on_done  = (ms_cnt == MS_W'(BEEP_ON_MS - 1));
    assign off_done = (ms_cnt == MS_W'(BEEP_OFF_MS - 1));
    // Compare with >= because the escalated gap may shrink below the count
    // already reached inside the current gap.
    assign gap_done = (ms_cnt >= gap_eff - 1'b1);

    // Run the tone only while staying in BEEP_ON; any other case clears the
    // phase on the same edge, which keeps buzzer_out at 0 outside BEEP_ON and
    // starts every beep from phase 0.
    assign tone_en  = (state == ST_BEEP_ON) & alarm_ringing & ~timeout & ~btn_stop & ~on_done;
    assign tone_clr = ~tone_en;

`ifdef ALARM_BUZZER_ESCALATE_EN
    logic [2:0]       esc_shift;
    logic [SEC_W-1:0] esc_mark;
    logic [MS_W-1:0]  gap_shifted;

    // Next escalation happens when the second count reaches 10*(shift+1).
    assign esc_mark    = SEC_W'(10) * (SEC_W'(esc_shift) + 1'b1);
    assign gap_shifted = MS_W'(GAP_MS) >> esc_shift;
    assign gap_eff     = (gap_shifted < MS_W'(BEEP_OFF_MS)) ? MS_W'(BEEP_OFF_MS) : gap_shifted;

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            esc_shift <= '0;
        end else if ((state == ST_IDLE) || rise) begin
            esc_shift <= '0;
        end else if (active && alarm_ringing && tick_1hz &&
                     (sec_next == esc_mark) && (esc_shift != 3'd7)) begin
            esc_shift <= esc_shift + 1'b1;
        end
    end
`else
    assign gap_eff = MS_W'(GAP_MS);
`endif

    tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_gen (
        .clk_1k (clk_1k),
        .rst_n  (rst_n),
        .en     (tone_en),
        .clr    (tone_clr),
        .tone   (buzzer_out)
    );

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ring_q      <= 1'b0;
            ms_cnt      <= '0;
            beep_cnt    <= '0;
            sec_cnt     <= '0;
            beep_led    <= 1'b0;
            ring_active <= 1'b0;
            auto_stop   <= 1'b0;
        end else begin
            ring_q    <= alarm_ringing;
            auto_stop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state       <= ST_BEEP_ON;
                        ms_cnt      <= '0;
                        beep_cnt    <= '0;
                        sec_cnt     <= '0;
                        beep_led    <= 1'b1;
                        ring_active <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!alarm_ringing) begin
                        state       <= ST_IDLE;
                        ms_cnt      <= '0;
                        beep_cnt    <= '0;
                        sec_cnt     <= '0;
                        ring_active <= 1'b0;
                    end
                end
                ST_BEEP_ON, ST_BEEP_OFF, ST_GAP: begin
                    // Ringing dropping outranks timeout, which outranks stop.
                    if (!alarm_ringing) begin
                        state       <= ST_IDLE;
                        ms_cnt      <= '0;
                        beep_cnt    <= '0;
                        sec_cnt     <= '0;
                        beep_led    <= 1'b0;
                        ring_active <= 1'b0;
                    end else if (timeout || btn_stop) begin
                        state     <= ST_HOLD;
                        ms_cnt    <= '0;
                        beep_led  <= 1'b0;
                        auto_stop <= timeout;
                    end else begin
                        if (tick_1hz) sec_cnt <= sec_next;
                        case (state)
                            ST_BEEP_ON: begin
                                if (on_done) begin
                                    ms_cnt   <= '0;
                                    beep_led <= 1'b0;
                                    if (beep_cnt == BC_W'(GROUP_BEEPS - 1)) begin
                                        state <= ST_GAP;
                                    end else begin
                                        beep_cnt <= beep_cnt + 1'b1;
                                        state    <= ST_BEEP_OFF;
                                    end
                                end else begin
                                    ms_cnt <= ms_cnt + 1'b1;
                                end
                            end
                            ST_BEEP_OFF: begin
                                if (off_done) begin
                                    ms_cnt   <= '0;
                                    beep_led <= 1'b1;
                                    state    <= ST_BEEP_ON;
                                end else begin
                                    ms_cnt <= ms_cnt + 1'b1;
                                end
                            end
                            default: begin
                                if (gap_done) begin
                                    ms_cnt   <= '0;
                                    beep_cnt <= '0;
                                    beep_led <= 1'b1;
                                    state    <= ST_BEEP_ON;
                                end else begin
                                    ms_cnt <= ms_cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ms_cnt      <= '0;
                    beep_cnt    <= '0;
                    sec_cnt     <= '0;
                    beep_led    <= 1'b0;
                    ring_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
